multi_port_prf: RTL and testbench

Parametrised multi-ported physical register file for the out-of-order core. It holds speculative and committed integer values indexed by physical register tag, plus a per-register ready bit used by issue logic. It sits between rename/dispatch (allocation), the execution units (writeback), and the issue queues (operand read).

---
 rtl/multi_port_prf.sv | 85 ++++++++
 tb/tb_multi_port_prf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_prf.sv
// Multi-ported physical register file: per-tag data plus ready bit, with optional
// same-cycle write-to-read forwarding and an optional hardwired zero register.
module multi_port_prf #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned NUM_READ  = 4,
  parameter int unsigned NUM_WRITE = 2,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG  = 1'b1,
  parameter int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ-1:0][AW-1:0]    rd_addr,
  output logic [NUM_READ-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]            rd_ready,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE-1:0][AW-1:0]   wr_addr,
  input  logic [NUM_WRITE-1:0][XLEN-1:0] wr_data,
  input  logic                           alloc_en,
  input  logic [AW-1:0]                  alloc_addr,
  input  logic                           flush,
  output logic [NUM_REGS-1:0]            ready_vec
);

  logic [XLEN-1:0]     mem [NUM_REGS];
  logic [NUM_REGS-1:0] ready_q;
  logic [NUM_REGS-1:0] ready_next;
  logic [NUM_WRITE-1:0] wr_ok;

  always_comb begin
    wr_ok = '0;
    for (int unsigned p = 0; p < NUM_WRITE; p++) begin
      wr_ok[p] = wr_en[p] && !(ZERO_REG && (wr_addr[p] == '0));
    end
  end

  // Ready priority: write set < alloc clear < flush set; tag 0 pinned when hardwired.
  always_comb begin
    ready_next = ready_q;
    for (int unsigned p = 0; p < NUM_WRITE; p++) begin
      if (wr_ok[p]) ready_next[wr_addr[p]] = 1'b1;
    end
    if (alloc_en) ready_next[alloc_addr] = 1'b0;
    if (flush) ready_next = '1;
    if (ZERO_REG) ready_next[0] = 1'b1;
  end

  // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      ready_q <= '1;
    end else begin
      for (int unsigned p = 0; p < NUM_WRITE; p++) begin
        if (wr_ok[p]) mem[wr_addr[p]] <= wr_data[p];
      end
      ready_q <= ready_next;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int unsigned r = 0; r < NUM_READ; r++) begin
      rd_data[r]  = mem[rd_addr[r]];
      rd_ready[r] = ready_q[rd_addr[r]];
      if (BYPASS) begin
        for (int unsigned p = 0; p < NUM_WRITE; p++) begin
          if (wr_en[p] && (wr_addr[p] == rd_addr[r])) begin
            rd_data[r]  = wr_data[p];
            rd_ready[r] = 1'b1;
          end
        end
      end
      if (ZERO_REG && (rd_addr[r] == '0)) begin
        rd_data[r]  = '0;
        rd_ready[r] = 1'b1;
      end
    end
  end

  assign ready_vec = ready_q;

endmodule

// File: tb/tb_multi_port_prf.sv
// Bench for multi_port_prf: two instances (bypass+zero-reg, and plain) driven with the
// same stimulus and compared every cycle against a behavioural model, plus literal checks.
module tb_multi_port_prf;
  localparam int XL = 32;
  localparam int NR = 64;
  localparam int NRD = 4;
  localparam int NW = 2;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic [NRD-1:0][AW-1:0] rd_addr;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][AW-1:0]  wr_addr;
  logic [NW-1:0][XL-1:0]  wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   flush;

  logic [NRD-1:0][XL-1:0] rd_data0, rd_data1;
  logic [NRD-1:0]         rd_ready0, rd_ready1;
  logic [NR-1:0]          ready_vec0, ready_vec1;

  int checks = 0;
  int errors = 0;

  logic [XL-1:0] m_data  [2][NR];
  logic          m_ready [2][NR];

  always #5 clk = ~clk;

  multi_port_prf #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NW),
                   .BYPASS(1'b1), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_ready(rd_ready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(flush), .ready_vec(ready_vec0));

  multi_port_prf #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NW),
                   .BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_ready(rd_ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(flush), .ready_vec(ready_vec1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instance 0 has forwarding and a hardwired tag 0; instance 1 has neither.
  function automatic void exp_read(input int k, input logic [AW-1:0] a,
                                   output logic [XL-1:0] d, output logic rdy);
    d   = m_data[k][a];
    rdy = m_ready[k][a];
    if (k == 0) begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wr_addr[p] == a) begin
          d   = wr_data[p];
          rdy = 1'b1;
        end
      end
      if (a == 0) begin
        d   = '0;
        rdy = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [XL-1:0] d;
    logic rdy;
    logic [NR-1:0] ev;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NRD; r++) begin
        exp_read(k, rd_addr[r], d, rdy);
        chk($sformatf("model_rd_data%0d[%0d]", k, r), 64'(k == 0 ? rd_data0[r] : rd_data1[r]), 64'(d));
        chk($sformatf("model_rd_ready%0d[%0d]", k, r), 64'(k == 0 ? rd_ready0[r] : rd_ready1[r]), 64'(rdy));
      end
      for (int i = 0; i < NR; i++) ev[i] = m_ready[k][i];
      chk($sformatf("model_ready_vec%0d", k), 64'(k == 0 ? ready_vec0 : ready_vec1), 64'(ev));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < NR; i++) begin
          m_data[k][i]  = '0;
          m_ready[k][i] = 1'b1;
        end
      end else begin
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && !(k == 0 && wr_addr[p] == 0)) begin
            m_data[k][wr_addr[p]]  = wr_data[p];
            m_ready[k][wr_addr[p]] = 1'b1;
          end
        end
        if (alloc_en && !(k == 0 && alloc_addr == 0)) m_ready[k][alloc_addr] = 1'b0;
        if (flush) for (int i = 0; i < NR; i++) m_ready[k][i] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        m_data[k][i] = 'x; m_ready[k][i] = 1'bx;
      end
    idle();
    rd_addr = '0;
    rst = 1'b1;
    @(negedge clk);
    clock();
    clock();
    idle();

    // Reset state: every tag reads zero and ready.
    settle();
    chk("reset_ready_vec0", 64'(ready_vec0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reset_ready_vec1", 64'(ready_vec1), 64'hFFFF_FFFF_FFFF_FFFF);
    for (int t = 0; t < NR; t += NRD) begin
      for (int r = 0; r < NRD; r++) rd_addr[r] = AW'(t + r);
      settle();
      chk("reset_rd_data1", 64'(rd_data1[t % NRD]), 64'h0);
      chk("reset_rd_ready1", 64'(rd_ready1[t % NRD]), 64'h1);
      clock();
    end

    // Alloc 5, then write 5 while reading it.
    alloc_en = 1'b1; alloc_addr = 6'd5; settle(); clock(); idle();
    wr_en = 2'b01; wr_addr[0] = 6'd5; wr_data[0] = 32'hDEAD_BEEF;
    rd_addr[1] = 6'd5; settle();
    chk("bypass_data", 64'(rd_data0[1]), 64'hDEAD_BEEF);
    chk("bypass_ready", 64'(rd_ready0[1]), 64'h1);
    chk("nobypass_ready", 64'(rd_ready1[1]), 64'h0);
    clock(); idle(); settle();
    chk("nobypass_next_data", 64'(rd_data1[1]), 64'hDEAD_BEEF);
    chk("nobypass_next_ready", 64'(rd_ready1[1]), 64'h1);
    clock();

    // Collision on tag 9.
    wr_en = 2'b11; wr_addr[0] = 6'd9; wr_addr[1] = 6'd9;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222; rd_addr[0] = 6'd9; settle();
    chk("collide_bypass", 64'(rd_data0[0]), 64'h2222);
    clock(); idle(); settle();
    chk("collide_stored0", 64'(rd_data0[0]), 64'h2222);
    chk("collide_stored1", 64'(rd_data1[0]), 64'h2222);
    clock();

    // Tag 0 write + alloc.
    wr_en = 2'b01; wr_addr[0] = 6'd0; wr_data[0] = 32'hFFFF;
    alloc_en = 1'b1; alloc_addr = 6'd0; rd_addr[2] = 6'd0; settle();
    chk("zero_bypass_data", 64'(rd_data0[2]), 64'h0);
    chk("zero_bypass_ready", 64'(rd_ready0[2]), 64'h1);
    clock(); idle(); settle();
    chk("zero_data", 64'(rd_data0[2]), 64'h0);
    chk("zero_ready", 64'(rd_ready0[2]), 64'h1);
    chk("zero_vec", 64'(ready_vec0[0]), 64'h1);
    chk("plain0_data", 64'(rd_data1[2]), 64'hFFFF);
    chk("plain0_ready", 64'(rd_ready1[2]), 64'h0);
    clock();

    // Allocs, flush, then alloc+write same tag.
    alloc_en = 1'b1; alloc_addr = 6'd3; settle(); clock();
    alloc_addr = 6'd7; settle(); clock(); idle(); settle();
    chk("alloc_vec3", 64'(ready_vec0[3]), 64'h0);
    chk("alloc_vec7", 64'(ready_vec1[7]), 64'h0);
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 6'd20; settle(); clock(); idle();
    rd_addr[3] = 6'd5; settle();
    chk("flush_vec0", 64'(ready_vec0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_vec1", 64'(ready_vec1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_data5", 64'(rd_data1[3]), 64'hDEAD_BEEF);
    clock();
    alloc_en = 1'b1; alloc_addr = 6'd12; wr_en = 2'b10; wr_addr[1] = 6'd12;
    wr_data[1] = 32'hABCD; settle(); clock(); idle();
    rd_addr[0] = 6'd12; settle();
    chk("allocwr_data", 64'(rd_data0[0]), 64'hABCD);
    chk("allocwr_ready", 64'(rd_ready0[0]), 64'h0);
    clock();

    // Write concurrent with reset is dropped.
    rst = 1'b1; wr_en = 2'b01; wr_addr[0] = 6'd4; wr_data[0] = 32'h55; settle(); clock(); idle();
    rd_addr[1] = 6'd4; settle();
    chk("rstwr_data", 64'(rd_data1[1]), 64'h0);
    chk("rstwr_ready", 64'(rd_ready1[1]), 64'h1);
    clock();

    // Randomized traffic, tags biased toward a small window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 29) == 0);
      alloc_en = ($urandom_range(0, 2) != 0);
      alloc_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
      for (int p = 0; p < NW; p++) begin
        wr_en[p] = ($urandom_range(0, 1) != 0);
        wr_addr[p] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
        wr_data[p] = $urandom;
      end
      for (int r = 0; r < NRD; r++)
        rd_addr[r] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
      settle();
      clock();
    end
    idle();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
